// File: rtl/fpmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_pkg
// Purpose : Shared constants for the FPmul test environment. This covers the
//           IEEE-754 single-precision field positions, the classification
//           flag indices and the default FPmul pipeline latency.
//           It also holds a helper that classifies a result word.
// Revision: 1.0 - initial release
// ============================================================================
package fpmul_pkg;

  localparam int WIDTH         = 32;
  localparam int EXP_MSB       = 30;
  localparam int EXP_LSB       = 23;
  localparam int MAN_MSB       = 22;
  localparam logic [EXP_MSB-EXP_LSB:0] EXP_ALL1 = 8'hFF;

  localparam int NUM_FLAGS     = 3;
  localparam int FLAG_NAN      = 2;
  localparam int FLAG_INF      = 1;
  localparam int FLAG_ZERO     = 0;

  // Default FPmul pipeline depth; data_maker and the bench rely on it too.
  localparam int FPMUL_LATENCY = 4;

  // The sign bit plays no part in classification, so only the exponent and
  // the mantissa are passed in. Denormals produce no flag.
  function automatic logic [NUM_FLAGS-1:0] classify(input logic [EXP_MSB:0] z);
    logic [EXP_MSB-EXP_LSB:0] e;
    logic [MAN_MSB:0]         m;
    logic [NUM_FLAGS-1:0]     f;
    e = z[EXP_MSB:EXP_LSB];
    m = z[MAN_MSB:0];
    f = '0;
    f[FLAG_NAN]  = (e == EXP_ALL1) && (m != '0);
    f[FLAG_INF]  = (e == EXP_ALL1) && (m == '0);
    f[FLAG_ZERO] = (e == '0)       && (m == '0);
    return f;
  endfunction

endpackage : fpmul_pkg
`default_nettype wire

// File: rtl/fpmul_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_sync_fifo
// Purpose : Single-clock circular-buffer FIFO with a show-ahead read.
//           Each pointer carries an extra wrap bit. The FIFO is empty when
//           the pointers are equal. It is full when the indices match and
//           the wrap bits differ.
// Ports   : clk, rst_n    - clock and asynchronous active-low reset
//           wr_en, wr_data - write strobe and word (caller guards against full
//                            unless a read happens on the same edge)
//           rd_en          - advance the head (ignored while empty)
//           rd_data        - head word, or zero while empty
//           empty, full    - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module fpmul_sync_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_rd = rd_en && !empty;

  // DEPTH is a power of two, so a plain increment wraps the index and
  // toggles the wrap bit at the same time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule : fpmul_sync_fifo
`default_nettype wire

// File: rtl/fpmul_out_collector.sv
`default_nettype none
// ============================================================================
// Module  : fpmul_out_collector
// Purpose : Receiving end of the FPmul result stream.
//           - A LATENCY-deep tag pipeline tracks which input samples were
//             valid.
//           - Matching FP_Z words are captured and classified as NaN, Inf
//             or zero.
//           - Captured words are buffered and drained over a valid/ready
//             handshake.
// Ports   : CLK, RST_n        - clock and asynchronous active-low reset
//           VIN               - FPmul input sample valid this cycle
//           DIN               - FPmul FP_Z result word
//           DOUT, DOUT_FLAGS  - head word and its {NaN, Inf, zero} flags
//           DOUT_VALID/READY  - downstream handshake
//           FULL              - buffer holds DEPTH entries
//           OVERFLOW          - sticky, set when a result was dropped
//           COUNT             - accepted results, saturating
// Revision: 1.0 - initial release
// ============================================================================
module fpmul_out_collector
  import fpmul_pkg::*;
#(
  parameter int WIDTH   = fpmul_pkg::WIDTH,
  parameter int LATENCY = FPMUL_LATENCY,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 VIN,
  input  logic [WIDTH-1:0]     DIN,
  output logic [WIDTH-1:0]     DOUT,
  output logic [NUM_FLAGS-1:0] DOUT_FLAGS,
  output logic                 DOUT_VALID,
  input  logic                 DOUT_READY,
  output logic                 FULL,
  output logic                 OVERFLOW,
  output logic [CNT_W-1:0]     COUNT
);

  localparam int EW = WIDTH + NUM_FLAGS;

  logic [LATENCY-1:0]   tag;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 fifo_empty;
  logic [NUM_FLAGS-1:0] din_flags;
  logic [EW-1:0]        head;
  logic [WIDTH-1:EXP_MSB+1] unused_sign;

  // Tag pipeline: VIN at edge t reaches the last stage at edge t+LATENCY-1,
  // so the matching DIN is captured on edge t+LATENCY.
  generate
    if (LATENCY == 1) begin : g_tag_single
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) tag <= '0;
        else        tag <= VIN;
      end
    end else begin : g_tag_shift
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) tag <= '0;
        else        tag <= {tag[LATENCY-2:0], VIN};
      end
    end
  endgenerate

  assign push = tag[LATENCY-1];
  assign pop  = DOUT_VALID && DOUT_READY;

  // A push into a full buffer is still accepted when the head leaves on the
  // same edge, because the freed slot is reused.
  assign accept = push && (!FULL || pop);

  assign unused_sign = DIN[WIDTH-1:EXP_MSB+1];
  assign din_flags   = classify(DIN[EXP_MSB:0]);

  fpmul_sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_n),
    .wr_en   (accept),
    .wr_data ({din_flags, DIN}),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (FULL)
  );

  assign DOUT       = head[WIDTH-1:0];
  assign DOUT_FLAGS = head[EW-1:WIDTH];
  assign DOUT_VALID = !fifo_empty;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      OVERFLOW <= 1'b0;
      COUNT    <= '0;
    end else begin
      if (push && !accept)
        OVERFLOW <= 1'b1;
      if (accept && (COUNT != {CNT_W{1'b1}}))
        COUNT <= COUNT + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule : fpmul_out_collector
`default_nettype wire

// File: tb/tb_fpmul_out_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fpmul_out_collector
// Purpose : Directed scoreboard bench for fpmul_out_collector. The stimulus
//           queues each expected {flags, word} at issue time. A negedge
//           monitor pops and compares on every handshake. It also checks
//           that the head holds stable while stalled.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fpmul_out_collector;
  import fpmul_pkg::*;

  localparam int W   = 32;
  localparam int LAT = FPMUL_LATENCY;
  localparam int D   = 8;
  localparam int CW  = 4;
  localparam logic [W-1:0] POISON = 32'hDEADBEEF;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          VIN = 1'b0;
  logic          DOUT_READY = 1'b0;
  logic [W-1:0]  DIN = POISON;
  logic [W-1:0]  DOUT;
  logic [2:0]    DOUT_FLAGS;
  logic          DOUT_VALID;
  logic          FULL;
  logic          OVERFLOW;
  logic [CW-1:0] COUNT;

  fpmul_out_collector #(
    .WIDTH   (W),
    .LATENCY (LAT),
    .DEPTH   (D),
    .CNT_W   (CW)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .VIN        (VIN),
    .DIN        (DIN),
    .DOUT       (DOUT),
    .DOUT_FLAGS (DOUT_FLAGS),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY),
    .FULL       (FULL),
    .OVERFLOW   (OVERFLOW),
    .COUNT      (COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] sb[$];

  // Stimulus-side delay line: the word issued with VIN is driven on DIN
  // LAT cycles later. Untagged cycles carry a poison word.
  logic         hv [1:LAT];
  logic [W-1:0] hd [1:LAT];

  // Monitor
  logic         hold = 1'b0;
  logic [W+2:0] held = '0;
  logic [W+2:0] want;

  always @(negedge CLK) begin
    if (!RST_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        checks++;
        if ({DOUT_FLAGS, DOUT} !== held) begin
          errors++;
          $display("FAIL stall_hold actual=%h required=%h", {DOUT_FLAGS, DOUT}, held);
        end
      end
      if (DOUT_VALID && DOUT_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word actual=%h required=none", {DOUT_FLAGS, DOUT});
        end else begin
          want = sb.pop_front();
          if ({DOUT_FLAGS, DOUT} !== want) begin
            errors++;
            $display("FAIL drain_word actual=%h required=%h", {DOUT_FLAGS, DOUT}, want);
          end
        end
      end
      hold = DOUT_VALID && !DOUT_READY;
      held = {DOUT_FLAGS, DOUT};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    for (int k = 1; k <= LAT; k++) begin
      hv[k] = 1'b0;
      hd[k] = POISON;
    end
  endtask

  // One cycle: drive inputs, advance to just after the next rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [2:0] f,
                      input logic acc, input logic rdy);
    VIN        = v;
    DOUT_READY = rdy;
    DIN        = hv[LAT] ? hd[LAT] : POISON;
    for (int k = LAT; k > 1; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[1] = v;
    hd[1] = d;
    if (v && acc) sb.push_back({f, d});
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, POISON, 3'b000, 1'b0, rdy);
  endtask

  task automatic do_reset();
    VIN = 1'b0;
    DOUT_READY = 1'b0;
    DIN = POISON;
    RST_n = 1'b0;
    clear_model();
    @(negedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    clear_model();
    // Reset state
    #12;
    chk("rst_valid", {31'd0, DOUT_VALID}, 32'd0);
    chk("rst_full", {31'd0, FULL}, 32'd0);
    chk("rst_dout", DOUT, 32'd0);
    chk("rst_flags", {29'd0, DOUT_FLAGS}, 32'd0);
    chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    chk("rst_count", {28'd0, COUNT}, 32'd0);
    @(negedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Single word, latency alignment
    step(1'b1, 32'h3F800000, 3'b000, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    chk("single_early", {31'd0, DOUT_VALID}, 32'd0);
    idle(1'b1);
    chk("single_valid", {31'd0, DOUT_VALID}, 32'd1);
    chk("single_dout", DOUT, 32'h3F800000);
    chk("single_flags", {29'd0, DOUT_FLAGS}, 32'd0);
    chk("single_count", {28'd0, COUNT}, 32'd1);
    repeat (2) idle(1'b1);
    chk("single_drained", sb.size(), 32'd0);

    // Classification
    step(1'b1, 32'h7FC00000, 3'b100, 1'b1, 1'b1);
    step(1'b1, 32'hFF800000, 3'b010, 1'b1, 1'b1);
    step(1'b1, 32'h80000000, 3'b001, 1'b1, 1'b1);
    step(1'b1, 32'h00000001, 3'b000, 1'b1, 1'b1);
    repeat (6) idle(1'b1);
    chk("class_drained", sb.size(), 32'd0);
    chk("class_count", {28'd0, COUNT}, 32'd5);

    // Full with simultaneous push and pop
    do_reset();
    for (int k = 1; k <= 9; k++) step(1'b1, 32'h40000000 + k, 3'b000, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("fp_not_full_7", {31'd0, FULL}, 32'd0);
    idle(1'b0);
    chk("fp_full_8", {31'd0, FULL}, 32'd1);
    chk("fp_count_8", {28'd0, COUNT}, 32'd8);
    idle(1'b1);
    chk("fp_full_after", {31'd0, FULL}, 32'd1);
    chk("fp_ovf", {31'd0, OVERFLOW}, 32'd0);
    chk("fp_count_9", {28'd0, COUNT}, 32'd9);
    repeat (10) idle(1'b1);
    chk("fp_drained", sb.size(), 32'd0);
    chk("fp_empty", {31'd0, DOUT_VALID}, 32'd0);

    // Back-pressure and overflow
    do_reset();
    for (int k = 1; k <= 10; k++)
      step(1'b1, 32'h41000000 + k, 3'b000, (k <= 8) ? 1'b1 : 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("ov_full_8", {31'd0, FULL}, 32'd1);
    chk("ov_ovf_pre", {31'd0, OVERFLOW}, 32'd0);
    idle(1'b0);
    chk("ov_ovf_9", {31'd0, OVERFLOW}, 32'd1);
    idle(1'b0);
    chk("ov_count", {28'd0, COUNT}, 32'd8);
    repeat (10) idle(1'b1);
    chk("ov_drained", sb.size(), 32'd0);
    chk("ov_empty", {31'd0, DOUT_VALID}, 32'd0);
    chk("ov_sticky", {31'd0, OVERFLOW}, 32'd1);

    // Gapped VIN pattern 1,0,1,1,0
    do_reset();
    step(1'b1, 32'd1, 3'b000, 1'b1, 1'b1);
    step(1'b0, 32'd2, 3'b000, 1'b0, 1'b1);
    step(1'b1, 32'd3, 3'b000, 1'b1, 1'b1);
    step(1'b1, 32'd4, 3'b000, 1'b1, 1'b1);
    step(1'b0, 32'd5, 3'b000, 1'b0, 1'b1);
    repeat (6) idle(1'b1);
    chk("gap_count", {28'd0, COUNT}, 32'd3);
    chk("gap_drained", sb.size(), 32'd0);

    // Counter saturation (CNT_W = 4)
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, 32'h3F800000 + k, 3'b000, 1'b1, 1'b1);
    repeat (6) idle(1'b1);
    chk("sat_count", {28'd0, COUNT}, 32'd15);
    chk("sat_drained", sb.size(), 32'd0);

    // Reset mid-stream: 2 buffered, 3 in flight
    do_reset();
    for (int k = 1; k <= 5; k++) step(1'b1, 32'h42000000 + k, 3'b000, 1'b1, 1'b0);
    idle(1'b0);
    chk("mid_valid_pre", {31'd0, DOUT_VALID}, 32'd1);
    chk("mid_count_pre", {28'd0, COUNT}, 32'd2);
    #2 RST_n = 1'b0;
    clear_model();
    #1;
    chk("mid_valid_rst", {31'd0, DOUT_VALID}, 32'd0);
    chk("mid_dout_rst", DOUT, 32'd0);
    chk("mid_count_rst", {28'd0, COUNT}, 32'd0);
    @(negedge CLK);
    #1 RST_n = 1'b1;
    @(posedge CLK);
    #1;
    repeat (8) idle(1'b1);
    chk("mid_no_stale", {31'd0, DOUT_VALID}, 32'd0);
    chk("mid_count_post", {28'd0, COUNT}, 32'd0);
    step(1'b1, 32'h00000000, 3'b001, 1'b1, 1'b1);
    repeat (3) idle(1'b1);
    chk("mid_first_early", {31'd0, DOUT_VALID}, 32'd0);
    idle(1'b1);
    chk("mid_first_valid", {31'd0, DOUT_VALID}, 32'd1);
    chk("mid_first_count", {28'd0, COUNT}, 32'd1);
    repeat (2) idle(1'b1);
    chk("mid_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fpmul_out_collector
`default_nettype wire
